minv_io_seq: RTL and testbench



---
 rtl/minv_io_seq.sv | 162 ++++++++++++++++
 tb/tb_minv_io_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/minv_io_seq.sv
`default_nettype none
// ============================================================================
// Module   : minv_io_seq
// Purpose  : Operand loader / result drainer for the 256-bit modular-inverse
//            engine. Collects a and p (8 words each, LSW first) from the host
//            stream, presents them on o_op_u / o_op_v, pulses o_minv_en, waits
//            for i_set_minv_rdy, captures x1 (u==1) or x2 and streams the
//            256-bit result back as eight words, LSW first.
// Ports    : clk, rst (async, active-high)
//            i_in_valid / o_in_ready / i_in_data     host operand stream
//            o_op_u, o_op_v                          engine load ports
//            o_minv_en, i_set_minv_rdy, i_u_is_one   controller handshake
//            i_res_x1, i_res_x2                      engine coefficients
//            o_out_valid / i_out_ready / o_out_data  result stream
//            o_out_last, o_out_err, o_busy           result framing / status
// Config   : MINV_TIMEOUT_EN - when defined, a 20-bit watchdog aborts WAIT
//            after TIMEOUT_CYC cycles and emits an all-zero result with err.
// Revision : 1.0 - initial release
// ============================================================================
module minv_io_seq #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 8
`ifdef MINV_TIMEOUT_EN
    ,
    parameter logic [19:0] TIMEOUT_CYC = 20'hFFFFF
`endif
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_in_valid,
    output logic                            o_in_ready,
    input  wire logic [WORD_W-1:0]          i_in_data,
    output logic [WORD_W*NWORDS-1:0]        o_op_u,
    output logic [WORD_W*NWORDS-1:0]        o_op_v,
    output logic                            o_minv_en,
    input  wire logic                       i_set_minv_rdy,
    input  wire logic                       i_u_is_one,
    input  wire logic [WORD_W*NWORDS-1:0]   i_res_x1,
    input  wire logic [WORD_W*NWORDS-1:0]   i_res_x2,
    output logic                            o_out_valid,
    input  wire logic                       i_out_ready,
    output logic [WORD_W-1:0]               o_out_data,
    output logic                            o_out_last,
    output logic                            o_out_err,
    output logic                            o_busy
);

    localparam int c_OP_W = WORD_W * NWORDS;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LOAD  = 3'd1;
    localparam logic [2:0] c_S_KICK  = 3'd2;
    localparam logic [2:0] c_S_WAIT  = 3'd3;
    localparam logic [2:0] c_S_DRAIN = 3'd4;

    logic [2:0]        r_state;
    logic [3:0]        r_wcnt;
    logic [2:0]        r_ocnt;
    logic              r_err;
    logic [c_OP_W-1:0] r_op_u;
    logic [c_OP_W-1:0] r_op_v;
    logic [c_OP_W-1:0] r_res;
`ifdef MINV_TIMEOUT_EN
    logic [19:0]       r_wdog;
`endif

    logic w_a_zero;
    logic w_in_fire;
    logic w_out_fire;

    assign w_a_zero   = (r_op_u == '0);
    assign w_in_fire  = i_in_valid && o_in_ready;
    assign w_out_fire = o_out_valid && i_out_ready;

    assign o_in_ready  = (r_state == c_S_IDLE) || (r_state == c_S_LOAD);
    assign o_busy      = (r_state != c_S_IDLE);
    assign o_minv_en   = (r_state == c_S_KICK) && !w_a_zero;
    assign o_out_valid = (r_state == c_S_DRAIN);
    assign o_out_data  = r_res[WORD_W-1:0];
    assign o_out_last  = (r_state == c_S_DRAIN) && (r_ocnt == 3'd7);
    assign o_out_err   = (r_state == c_S_DRAIN) && r_err;
    assign o_op_u      = r_op_u;
    assign o_op_v      = r_op_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_wcnt  <= 4'd0;
            r_ocnt  <= 3'd0;
            r_err   <= 1'b0;
            r_op_u  <= '0;
            r_op_v  <= '0;
            r_res   <= '0;
`ifdef MINV_TIMEOUT_EN
            r_wdog  <= 20'd0;
`endif
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_in_fire) begin
                        r_op_u[WORD_W-1:0] <= i_in_data;
                        r_wcnt             <= 4'd1;
                        r_state            <= c_S_LOAD;
                    end
                end
                c_S_LOAD: begin
                    if (w_in_fire) begin
                        // Slots 0-7 belong to a, 8-15 to p.
                        if (!r_wcnt[3])
                            r_op_u[r_wcnt[2:0]*WORD_W +: WORD_W] <= i_in_data;
                        else
                            r_op_v[r_wcnt[2:0]*WORD_W +: WORD_W] <= i_in_data;
                        r_wcnt <= r_wcnt + 4'd1;   // wraps to 0 after slot 15
                        if (r_wcnt == 4'd15)
                            r_state <= c_S_KICK;
                    end
                end
                c_S_KICK: begin
`ifdef MINV_TIMEOUT_EN
                    r_wdog <= 20'd0;
`endif
                    if (w_a_zero) begin
                        // No inverse of zero: skip the engine entirely.
                        r_err   <= 1'b1;
                        r_res   <= '0;
                        r_state <= c_S_DRAIN;
                    end else begin
                        r_state <= c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    // Completion wins over a same-cycle timeout.
                    if (i_set_minv_rdy) begin
                        r_res   <= i_u_is_one ? i_res_x1 : i_res_x2;
                        r_err   <= 1'b0;
                        r_state <= c_S_DRAIN;
                    end
`ifdef MINV_TIMEOUT_EN
                    else if (r_wdog == TIMEOUT_CYC - 20'd1) begin
                        r_err   <= 1'b1;
                        r_res   <= '0;
                        r_state <= c_S_DRAIN;
                    end else begin
                        r_wdog <= r_wdog + 20'd1;
                    end
`endif
                end
                c_S_DRAIN: begin
                    if (w_out_fire) begin
                        r_res  <= r_res >> WORD_W;
                        r_ocnt <= r_ocnt + 3'd1;   // wraps to 0 after word 7
                        if (r_ocnt == 3'd7)
                            r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_minv_io_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_minv_io_seq
// Purpose  : Scoreboard bench for minv_io_seq. Stimulus pushes the expected
//            result words into a queue; a monitor pops and compares on every
//            result transfer. Watchdog cases are built when MINV_TIMEOUT_EN
//            is defined (TIMEOUT_CYC overridden to 100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_minv_io_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [31:0]  i_in_data = '0;
    logic [255:0] o_op_u, o_op_v;
    logic         o_minv_en;
    logic         i_set_minv_rdy = 1'b0;
    logic         i_u_is_one = 1'b0;
    logic [255:0] i_res_x1 = '0;
    logic [255:0] i_res_x2 = '0;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [31:0]  o_out_data;
    logic         o_out_last;
    logic         o_out_err;
    logic         o_busy;

    always #5 clk = ~clk;

    minv_io_seq #(
        .WORD_W(32)
`ifdef MINV_TIMEOUT_EN
        , .TIMEOUT_CYC(20'd100)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_op_u(o_op_u), .o_op_v(o_op_v), .o_minv_en(o_minv_en),
        .i_set_minv_rdy(i_set_minv_rdy), .i_u_is_one(i_u_is_one),
        .i_res_x1(i_res_x1), .i_res_x2(i_res_x2),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_data(o_out_data), .o_out_last(o_out_last),
        .o_out_err(o_out_err), .o_busy(o_busy)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   en_count = 0;
    logic bp_mode  = 1'b0;

`ifdef MINV_TIMEOUT_EN
    localparam int c_D1 = 60;
`else
    localparam int c_D1 = 200;
`endif

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every result transfer.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data  = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (o_minv_en) en_count++;
            if (stall_prev && o_out_valid)
                check("stall_hold", o_out_data, prev_data);
            if (o_out_valid && i_out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, expected none", o_out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", o_out_data, e.d);
                    check("out_last", o_out_last, e.last);
                    check("out_err",  o_out_err,  e.err);
                end
            end
            stall_prev = o_out_valid && !i_out_ready;
            prev_data  = o_out_data;
        end
    end

    // Sink: always ready, or toggling every cycle under backpressure.
    initial begin
        i_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) i_out_ready = ~i_out_ready;
            else         i_out_ready = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        i_in_valid = 1'b1;
        i_in_data  = w;
        tick();
        i_in_valid = 1'b0;
    endtask

    // spur >= 0: pulse a stray completion before that word index.
    task automatic load(input logic [255:0] a, input logic [255:0] p,
                        input bit gaps, input int spur);
        for (int k = 0; k < 16; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            if (k == spur) begin
                i_set_minv_rdy = 1'b1;
                i_u_is_one     = 1'b1;
                i_res_x1       = '1;
                tick();
                i_set_minv_rdy = 1'b0;
                i_res_x1       = '0;
                check("spur_ignored", {o_busy, o_in_ready, o_out_valid}, 3'b110);
            end
            if (k < 8) send(a[k*32 +: 32]);
            else       send(p[(k-8)*32 +: 32]);
        end
    endtask

    task automatic push_exp(input logic [255:0] res, input logic err);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.d    = res[k*32 +: 32];
            e.last = (k == 7);
            e.err  = err;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && !o_busy) break;
            tick();
        end
        check(name, {sb.size() == 0, o_busy, o_in_ready}, 3'b101);
    endtask

    // Load, kick, model the controller, and push the expected result.
    task automatic start_case(input logic [255:0] a, input logic [255:0] p,
                              input logic u1, input logic [255:0] x1,
                              input logic [255:0] x2, input int delay,
                              input bit gaps, input int spur);
        if (a == '0) push_exp('0, 1'b1);
        else         push_exp(u1 ? x1 : x2, 1'b0);
        load(a, p, gaps, spur);
        check("kick_minv_en", o_minv_en, a != '0);
        check("kick_op_u", o_op_u, a);
        check("kick_op_v", o_op_v, p);
        tick();
        if (a != '0) begin
            repeat (delay - 1) tick();
            check("wait_no_valid", {o_out_valid, o_busy}, 2'b01);
            i_set_minv_rdy = 1'b1;
            i_u_is_one     = u1;
            i_res_x1       = x1;
            i_res_x2       = x2;
            tick();
            i_set_minv_rdy = 1'b0;
            i_res_x1       = '0;
            i_res_x2       = '0;
        end
        check("first_valid", o_out_valid, 1'b1);
    endtask

    task automatic run_case(input string name, input logic [255:0] a,
                            input logic [255:0] p, input logic u1,
                            input logic [255:0] x1, input logic [255:0] x2,
                            input int delay, input bit bp, input bit gaps,
                            input int spur);
        int en0;
        en0     = en_count;
        bp_mode = bp;
        start_case(a, p, u1, x1, x2, delay, gaps, spur);
        wait_done(name);
        bp_mode = 1'b0;
        check("minv_en_pulses", en_count - en0, (a != '0) ? 1 : 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {o_in_ready, o_busy, o_minv_en, o_out_valid, o_out_last,
                     o_out_err, o_out_data, o_op_u, o_op_v},
              {1'b1, 5'b0, 32'h0, 256'h0, 256'h0});
    endtask

    initial begin
        logic [255:0] big;
        logic [255:0] ga;
        logic [255:0] gp;
        big = 256'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF;
        ga  = 256'hDEADBEEF_00000001_CAFEF00D_12345678_9ABCDEF0_0F0F0F0F_A5A5A5A5_00000003;
        gp  = 256'hFFFFFFFF_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFC5;

        #2;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_case("x1_path", 256'd3, 256'd7, 1'b1, 256'd5, 256'hBAD, c_D1, 1'b0, 1'b0, -1);
        run_case("x2_backpressure", 256'd5, 256'd11, 1'b0, 256'h1234, big, 10, 1'b1, 1'b0, -1);
        run_case("zero_operand", 256'd0, 256'd7, 1'b1, 256'd9, 256'd9, 1, 1'b0, 1'b0, -1);
        run_case("gapped_spurious", ga, gp, 1'b0, 256'h77, 256'h5555_AAAA, 20, 1'b0, 1'b1, 10);

        // Reset mid-WAIT: async, checked before any clock edge.
        load(256'd3, 256'd7, 1'b0, -1);
        repeat (6) tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_mid_wait");
        #3 rst = 1'b0;
        tick();
        run_case("reload_after_wait_rst", 256'd9, 256'd13, 1'b1, 256'd3, 256'd0, 15, 1'b0, 1'b0, -1);

        // Reset mid-DRAIN: stop after a few words are drained.
        start_case(256'd3, 256'd7, 1'b0, 256'd0, big, 12, 1'b0, -1);
        for (int i = 0; i < 50 && sb.size() > 5; i++) tick();
        check("mid_drain_progress", sb.size(), 5);
        #2 rst = 1'b1;
        sb.delete();
        #1 check_reset_outputs("reset_mid_drain");
        #3 rst = 1'b0;
        tick();
        run_case("reload_after_drain_rst", 256'd3, 256'd7, 1'b1, 256'd5, 256'd1, 8, 1'b1, 1'b0, -1);

`ifdef MINV_TIMEOUT_EN
        // Watchdog expiry: 100 WAIT cycles, then an all-zero error result.
        push_exp('0, 1'b1);
        load(256'd3, 256'd7, 1'b0, -1);
        check("wdog_kick", o_minv_en, 1'b1);
        tick();
        repeat (99) tick();
        check("wdog_not_early", {o_out_valid, o_busy}, 2'b01);
        tick();
        check("wdog_drain", {o_out_valid, o_out_err}, 2'b11);
        wait_done("wdog_timeout");
        // Completion on exactly cycle 100 beats the timeout.
        run_case("wdog_priority", 256'd3, 256'd7, 1'b1, 256'd5, 256'd0, 100, 1'b0, 1'b0, -1);
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
